// File: rtl/clock_set_ctrl.sv
// Time-set controller for the seconds clock.
// Sequences run, digit edit and commit of the BCD seconds counters.
module clock_set_ctrl #(
    parameter int BLINK_DIV   = 25000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       mode_i,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [3:0] sw_i,
    input  logic [3:0] cur_unit_i,
    input  logic [3:0] cur_decimal_i,
    output logic       run_en_o,
    output logic       load_o,
    output logic [3:0] load_unit_o,
    output logic [3:0] load_decimal_o,
    output logic       blank_unit_o,
    output logic       blank_decimal_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_UNIT = 2'b01,
        SET_DEC  = 2'b10,
        COMMIT   = 2'b11
    } state_t;

    localparam int CW = $clog2(BLINK_DIV);

    logic [SYNC_STAGES-1:0] mode_sync, inc_sync, load_sync;
    logic                   mode_prev, inc_prev, load_prev;
    logic                   mode_press, inc_press, load_press;

    state_t          state_q, state_n;
    logic [3:0]      unit_q, unit_n;
    logic [3:0]      dec_q, dec_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            phase_q, phase_n;
    logic            edit_n;

    assign mode_press = mode_sync[SYNC_STAGES-1] & ~mode_prev;
    assign inc_press  = inc_sync[SYNC_STAGES-1] & ~inc_prev;
    assign load_press = load_sync[SYNC_STAGES-1] & ~load_prev;

    assign load_unit_o    = unit_q;
    assign load_decimal_o = dec_q;

    // Button synchronizers and rising-edge history.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mode_sync <= '0;
            inc_sync  <= '0;
            load_sync <= '0;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
            load_prev <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], mode_i};
            inc_sync  <= {inc_sync[SYNC_STAGES-2:0], inc_i};
            load_sync <= {load_sync[SYNC_STAGES-2:0], load_i};
            mode_prev <= mode_sync[SYNC_STAGES-1];
            inc_prev  <= inc_sync[SYNC_STAGES-1];
            load_prev <= load_sync[SYNC_STAGES-1];
        end
    end

    // State, edit values and blink timer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            unit_q  <= '0;
            dec_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_n;
            unit_q  <= unit_n;
            dec_q   <= dec_n;
            cnt_q   <= cnt_n;
            phase_q <= phase_n;
        end
    end

    // Next state, edit updates (mode beats load beats inc) and blink timer.
    always_comb begin
        state_n = state_q;
        unit_n  = unit_q;
        dec_n   = dec_q;
        cnt_n   = cnt_q;
        phase_n = phase_q;
        unique case (state_q)
            RUN: begin
                if (mode_press) begin
                    unit_n  = (cur_unit_i > 4'd9) ? 4'd9 : cur_unit_i;
                    dec_n   = (cur_decimal_i > 4'd5) ? 4'd5 : cur_decimal_i;
                    state_n = SET_UNIT;
                end
            end
            SET_UNIT: begin
                if (mode_press) begin
                    state_n = SET_DEC;
                end else if (load_press) begin
                    if (sw_i <= 4'd9) unit_n = sw_i;
                end else if (inc_press) begin
                    unit_n = (unit_q == 4'd9) ? 4'd0 : unit_q + 4'd1;
                end
            end
            SET_DEC: begin
                if (mode_press) begin
                    state_n = COMMIT;
                end else if (load_press) begin
                    if (sw_i <= 4'd5) dec_n = sw_i;
                end else if (inc_press) begin
                    dec_n = (dec_q == 4'd5) ? 4'd0 : dec_q + 4'd1;
                end
            end
            COMMIT: begin
                state_n = RUN;
            end
        endcase
        edit_n = (state_n == SET_UNIT) || (state_n == SET_DEC);
        if (edit_n && (state_n != state_q || inc_press || load_press)) begin
            cnt_n   = '0;
            phase_n = 1'b0;
        end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
            cnt_n   = '0;
            phase_n = ~phase_q;
        end else begin
            cnt_n = cnt_q + CW'(1);
        end
    end

    // Registered outputs follow the next state so they line up with it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            run_en_o        <= 1'b0;
            load_o          <= 1'b0;
            blank_unit_o    <= 1'b0;
            blank_decimal_o <= 1'b0;
            state_o         <= 2'b00;
        end else begin
            run_en_o        <= (state_n == RUN);
            load_o          <= (state_n == COMMIT);
            blank_unit_o    <= (state_n == SET_UNIT) && phase_n;
            blank_decimal_o <= (state_n == SET_DEC) && phase_n;
            state_o         <= state_n;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl.
// Commit loads are scored against a queue of expected values.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       mode_i = 1'b0;
    logic       inc_i = 1'b0;
    logic       load_i = 1'b0;
    logic [3:0] sw_i = 4'd0;
    logic [3:0] cur_unit_i = 4'd0;
    logic [3:0] cur_decimal_i = 4'd0;
    logic       run_en_o;
    logic       load_o;
    logic [3:0] load_unit_o;
    logic [3:0] load_decimal_o;
    logic       blank_unit_o;
    logic       blank_decimal_o;
    logic [1:0] state_o;

    int n_chk = 0;
    int n_pass = 0;
    int n_loads = 0;
    logic [7:0] exp_q[$];

    clock_set_ctrl #(.BLINK_DIV(4), .SYNC_STAGES(2)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .mode_i(mode_i),
        .inc_i(inc_i),
        .load_i(load_i),
        .sw_i(sw_i),
        .cur_unit_i(cur_unit_i),
        .cur_decimal_i(cur_decimal_i),
        .run_en_o(run_en_o),
        .load_o(load_o),
        .load_unit_o(load_unit_o),
        .load_decimal_o(load_decimal_o),
        .blank_unit_o(blank_unit_o),
        .blank_decimal_o(blank_decimal_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i, input logic l);
        mode_i = m;
        inc_i  = i;
        load_i = l;
        tick();
        mode_i = 1'b0;
        inc_i  = 1'b0;
        load_i = 1'b0;
        repeat (4) tick();
    endtask

    // Scoreboard: every load strobe must match the oldest queued commit.
    always @(negedge clk) begin
        if (rst_i && load_o) begin
            n_loads++;
            check("load_pending", 8'(exp_q.size() > 0), 8'd1);
            check("load_state", 8'(state_o), 8'd3);
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("load_unit", 8'(load_unit_o), 8'(e[7:4]));
                check("load_dec", 8'(load_decimal_o), 8'(e[3:0]));
            end
        end
    end

    initial begin
        int n;
        // reset held for 3 cycles
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_ctl", 8'({run_en_o, load_o, blank_unit_o,
                                 blank_decimal_o, state_o}), 8'd0);
            check("rst_vals", {load_unit_o, load_decimal_o}, 8'd0);
        end
        rst_i = 1'b1;
        tick();
        check("rel_run", 8'(run_en_o), 8'd1);
        check("rel_state", 8'(state_o), 8'd0);
        check("rel_load", 8'(load_o), 8'd0);

        // edit with wrap
        cur_unit_i = 4'd7;
        cur_decimal_i = 4'd4;
        press(1, 0, 0);
        check("ed_state", 8'(state_o), 8'd1);
        check("ed_run", 8'(run_en_o), 8'd0);
        check("ed_cap_u", 8'(load_unit_o), 8'd7);
        for (int k = 0; k < 4; k++) begin
            press(0, 1, 0);
            check("ed_inc_u", 8'(load_unit_o), 8'((8 + k) % 10));
        end
        press(1, 0, 0);
        check("ed_state2", 8'(state_o), 8'd2);
        check("ed_cap_d", 8'(load_decimal_o), 8'd4);
        press(0, 1, 0);
        check("ed_inc_d5", 8'(load_decimal_o), 8'd5);
        press(0, 1, 0);
        check("ed_inc_d0", 8'(load_decimal_o), 8'd0);
        exp_q.push_back({4'd1, 4'd0});
        press(1, 0, 0);
        check("cm_state", 8'(state_o), 8'd0);
        check("cm_run", 8'(run_en_o), 8'd1);
        check("cm_nload", 8'(n_loads), 8'd1);

        // clamp on capture and switch limits
        cur_unit_i = 4'd12;
        cur_decimal_i = 4'd8;
        press(1, 0, 0);
        check("cl_u", 8'(load_unit_o), 8'd9);
        check("cl_d", 8'(load_decimal_o), 8'd5);
        sw_i = 4'd3;
        press(0, 0, 1);
        check("sw_u3", 8'(load_unit_o), 8'd3);
        sw_i = 4'd9;
        press(0, 0, 1);
        check("sw_u9", 8'(load_unit_o), 8'd9);
        sw_i = 4'd12;
        press(0, 0, 1);
        check("sw_u12", 8'(load_unit_o), 8'd9);

        // held inc: exactly one step
        inc_i = 1'b1;
        repeat (20) tick();
        inc_i = 1'b0;
        repeat (4) tick();
        check("held_inc", 8'(load_unit_o), 8'd0);

        // mode and inc together: mode wins
        press(1, 1, 0);
        check("sim_state", 8'(state_o), 8'd2);
        check("sim_unit", 8'(load_unit_o), 8'd0);
        sw_i = 4'd6;
        press(0, 0, 1);
        check("sw_d6", 8'(load_decimal_o), 8'd5);
        sw_i = 4'd3;
        press(0, 0, 1);
        check("sw_d3", 8'(load_decimal_o), 8'd3);
        sw_i = 4'd1;
        press(0, 1, 1);
        check("inc_ld", 8'(load_decimal_o), 8'd1);
        exp_q.push_back({4'd0, 4'd1});
        press(1, 0, 0);
        check("cm2_state", 8'(state_o), 8'd0);

        // blink pattern in SET_UNIT
        cur_unit_i = 4'd2;
        cur_decimal_i = 4'd3;
        mode_i = 1'b1;
        tick();
        mode_i = 1'b0;
        n = 0;
        while (state_o != 2'b01 && n < 10) begin
            tick();
            n++;
        end
        check("bl_enter", 8'(state_o), 8'd1);
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) tick();
            check("bl_u", 8'(blank_unit_o), 8'((i / 4) % 2));
            check("bl_d", 8'(blank_decimal_o), 8'd0);
        end
        inc_i = 1'b1;
        tick();
        inc_i = 1'b0;
        n = 0;
        while (load_unit_o != 4'd3 && n < 10) begin
            tick();
            n++;
        end
        check("bl_inc", 8'(load_unit_o), 8'd3);
        check("bl_clr", 8'(blank_unit_o), 8'd0);
        for (int j = 1; j <= 4; j++) begin
            tick();
            check("bl_rst", 8'(blank_unit_o), 8'(j == 4));
        end

        // reset mid-edit in SET_DEC
        press(1, 0, 0);
        check("dec_state", 8'(state_o), 8'd2);
        check("dec_blank", 8'({blank_unit_o, blank_decimal_o}), 8'd0);
        rst_i = 1'b0;
        tick();
        check("mr_state", 8'(state_o), 8'd0);
        check("mr_load", 8'(load_o), 8'd0);
        check("mr_vals", {load_unit_o, load_decimal_o}, 8'd0);
        tick();
        rst_i = 1'b1;
        tick();
        check("mr_run", 8'(run_en_o), 8'd1);
        check("mr_state2", 8'(state_o), 8'd0);
        repeat (3) tick();
        check("nloads", 8'(n_loads), 8'd2);
        check("q_empty", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-set controller for the seconds clock: sequences run, edit and commit of the BCD unit and decimal seconds counters.
- Takes raw button and switch inputs. Drives count-enable, a one-cycle parallel-load strobe with the load values, and blink-blank controls for the two 7-segment digits.
- Sits between the board inputs and the seconds counter/decoder chain.

Parameters:
- BLINK_DIV, 25000000, clock cycles per blink half-period in edit states (minimum 2).
- SYNC_STAGES, 2, synchronizer flops per button input (minimum 2).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-low.
- mode_i  in  1  mode button, asynchronous, active-high.
- inc_i  in  1  increment button, asynchronous, active-high.
- load_i  in  1  switch-load button, asynchronous, active-high.
- sw_i  in  4  switch value for direct digit load; treated as quasi-static and sampled at the load_i edge without synchronization.
- cur_unit_i  in  4  current unit-seconds BCD from the counter.
- cur_decimal_i  in  4  current decimal-seconds BCD from the counter.
- run_en_o  out  1  counter count-enable.
- load_o  out  1  one-cycle parallel-load strobe to the counter.
- load_unit_o  out  4  unit value to load.
- load_decimal_o  out  4  decimal value to load.
- blank_unit_o  out  1  blank the unit digit.
- blank_decimal_o  out  1  blank the decimal digit.
- state_o  out  2  current state: 00 RUN, 01 SET_UNIT, 10 SET_DEC, 11 COMMIT.

Behaviour:
- Reset and clocking:
  - Single clock domain; rst_i is sampled only on the clk_i rising edge.
  - While rst_i=0: state=RUN, edit_unit=0, edit_decimal=0, blink counter=0, synchronizers and edge registers cleared.
  - All registered outputs read 0 during reset, including run_en_o and state_o=00.
  - run_en_o=1 from the first edge with rst_i=1 onward.
- Button inputs:
  - Each button passes through a SYNC_STAGES-deep synchronizer, then a rising-edge detector.
  - A "press" is a one-cycle pulse, asserted SYNC_STAGES+1 clock edges after the input is first sampled high.
  - Held buttons produce exactly one press. No debounce is done here; inputs are pre-debounced.
- Output timing: all outputs are registered and reflect the state/edit registers after the same edge.
- RUN:
  - run_en_o=1, blanks=0, load_o=0.
  - mode press: capture edit_unit<=cur_unit_i and edit_decimal<=cur_decimal_i, then go to SET_UNIT.
  - inc and load presses are ignored.
- SET_UNIT:
  - run_en_o=0.
  - inc press: edit_unit <= (edit_unit==9) ? 0 : edit_unit+1.
  - load press: if sw_i<=9 then edit_unit<=sw_i; otherwise the press is ignored and the value is unchanged.
  - mode press: go to SET_DEC.
- SET_DEC:
  - run_en_o=0.
  - inc press: edit_decimal <= (edit_decimal==5) ? 0 : edit_decimal+1.
  - load press: if sw_i<=5 then edit_decimal<=sw_i; otherwise ignored.
  - mode press: go to COMMIT.
- COMMIT:
  - Lasts exactly one cycle: load_o=1, load_unit_o=edit_unit, load_decimal_o=edit_decimal, run_en_o=0.
  - Then unconditionally RUN. Any press during COMMIT is dropped.
- load_unit_o and load_decimal_o always show the edit registers; they are meaningful only while load_o=1.
- Simultaneous presses in the same cycle: mode has priority over inc and load, which are discarded. inc and load together: load wins.
- Blink:
  - On entry to SET_UNIT or SET_DEC the blink counter clears and the blank phase is 0.
  - The blank phase toggles every BLINK_DIV cycles.
  - blank_unit_o = phase only in SET_UNIT; blank_decimal_o = phase only in SET_DEC; both are 0 otherwise.
  - Any inc or load press in an edit state clears the counter and the phase, so the digit is shown immediately.
- Edit values: never exceed 9 (unit) or 5 (decimal). Captured cur_* values outside range are clamped on capture: unit >9 -> 9, decimal >5 -> 5.
- Reset mid-edit: returns to RUN immediately, no load_o pulse, and the edit values are lost.

Test Plan:
- Reset release: hold rst_i=0 for 3 cycles, then release -> all outputs 0 during reset; run_en_o=1 and state_o=00 on the first edge after release; load_o stays 0.
- Edit with wrap:
  - cur_unit_i=7, cur_decimal_i=4; press mode -> state_o=01, run_en_o=0.
  - Press inc 4 times -> edit_unit 8, 9, 0, 1.
  - Press mode -> state 10; press inc twice -> decimal 5, 0.
  - Press mode -> one-cycle load_o=1 with load_unit_o=1, load_decimal_o=0, then state 00 and run_en_o=1.
- Switch load limits: in SET_UNIT, sw_i=9 plus load -> unit 9; sw_i=12 plus load -> unit stays 9. In SET_DEC, sw_i=6 plus load -> ignored; sw_i=3 plus load -> decimal 3.
- Held button: hold inc high for 20 cycles in SET_UNIT -> exactly one increment. Press appears SYNC_STAGES+1=3 edges after the first high sample.
- Simultaneous presses: mode and inc rise in the same cycle in SET_UNIT -> state goes to 10 and edit_unit is unchanged.
- Blink and reset mid-edit (BLINK_DIV=4):
  - In SET_UNIT, blank_unit_o follows 0000 1111 0000 and blank_decimal_o stays 0.
  - An inc press clears blank_unit_o at once.
  - Assert rst_i=0 in SET_DEC -> state 00 after the edge, no load_o pulse.
